// File: rtl/tone_sequencer_if.sv
// Control and output bundle for one melody voice feeding the audio arbiter.
// The controller drives enable/restart/selection; the sequencer drives the tone.
interface tone_sequencer_if;
  logic       enable;
  logic       restart;
  logic [1:0] melody_sel;
  logic       sound;
  logic       busy;
  logic [2:0] note_idx;

  modport master (
    output enable,
    output restart,
    output melody_sel,
    input  sound,
    input  busy,
    input  note_idx
  );

  modport slave (
    input  enable,
    input  restart,
    input  melody_sel,
    output sound,
    output busy,
    output note_idx
  );
endinterface

// File: rtl/tone_sequencer.sv
// Square-wave melody generator: steps a fixed note table, one note per
// NOTE_CYCLES clocks, each note a 50% square wave of its half-period.
module tone_sequencer #(
  parameter int unsigned NOTE_CYCLES = 1562500,
  parameter int unsigned HALF_SHIFT  = 0,
  parameter int unsigned DIV_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  tone_sequencer_if.slave sq
);

  localparam int unsigned DUR_W =
    (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  function automatic logic [15:0] note_tab(
    input logic [1:0] sel,
    input logic [2:0] idx
  );
    logic [15:0] v;
    v = '0;
    case (sel)
      2'd0: begin
        case (idx)
          3'd0:    v = 16'd14205;
          3'd1:    v = 16'd11939;
          default: v = '0;
        endcase
      end
      2'd1: begin
        case (idx)
          3'd0:    v = 16'd23900;
          3'd1:    v = 16'd18968;
          3'd2:    v = 16'd15944;
          3'd3:    v = 16'd11939;
          3'd4:    v = 16'd0;
          3'd5:    v = 16'd15944;
          3'd6:    v = 16'd11939;
          default: v = 16'd11939;
        endcase
      end
      2'd2: begin
        case (idx)
          3'd0:    v = 16'd31888;
          3'd1:    v = 16'd37879;
          3'd2:    v = 16'd47710;
          default: v = '0;
        endcase
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] mel_len(input logic [1:0] sel);
    logic [3:0] n;
    case (sel)
      2'd0:    n = 4'd2;
      2'd1:    n = 4'd8;
      2'd2:    n = 4'd4;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [DIV_W-1:0] half_period(
    input logic [1:0] sel,
    input logic [2:0] idx
  );
    return DIV_W'(note_tab(sel, idx) >> HALF_SHIFT);
  endfunction

  // Rests park the half counter at 0; it is never consulted for them.
  function automatic logic [DIV_W-1:0] half_load(
    input logic [DIV_W-1:0] hp
  );
    return (hp == '0) ? '0 : hp - 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       idx_q, idx_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic             sound_q, sound_d;
  logic             busy_q, busy_d;

  logic             go_idle;
  logic             go_start;
  logic             go_play;
  logic             last_note;
  logic [DIV_W-1:0] hp_cur;
  logic [DIV_W-1:0] hp_nxt;
  logic [DIV_W-1:0] hp_start;
  logic [2:0]       idx_nxt;

  assign idx_nxt   = idx_q + 3'd1;
  assign hp_cur    = half_period(sel_q, idx_q);
  assign hp_nxt    = half_period(sel_q, idx_nxt);
  assign hp_start  = half_period(sq.melody_sel, 3'd0);
  assign last_note = ({1'b0, idx_q} == (mel_len(sel_q) - 4'd1));

  assign go_idle  = !sq.enable;
  assign go_start = sq.enable && (state_q == IDLE || sq.restart);
  assign go_play  = sq.enable && !sq.restart && state_q == PLAY;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    half_d  = half_q;
    sound_d = sound_q;
    busy_d  = busy_q;
    unique case (1'b1)
      go_idle: begin
        state_d = IDLE;
        idx_d   = '0;
        dur_d   = '0;
        half_d  = '0;
        sound_d = 1'b0;
        busy_d  = 1'b0;
      end
      go_start: begin
        sel_d   = sq.melody_sel;
        idx_d   = '0;
        dur_d   = DUR_LAST;
        half_d  = half_load(hp_start);
        sound_d = 1'b0;
        if (mel_len(sq.melody_sel) == 4'd0) begin
          state_d = DONE;
          busy_d  = 1'b0;
        end else begin
          state_d = PLAY;
          busy_d  = 1'b1;
        end
      end
      go_play: begin
        if (dur_q == '0) begin
          sound_d = 1'b0;
          if (last_note) begin
            state_d = DONE;
            busy_d  = 1'b0;
          end else begin
            idx_d  = idx_nxt;
            dur_d  = DUR_LAST;
            half_d = half_load(hp_nxt);
          end
        end else begin
          dur_d = dur_q - 1'b1;
          if (hp_cur == '0) begin
            sound_d = 1'b0;
          end else if (half_q == '0) begin
            half_d  = hp_cur - 1'b1;
            sound_d = !sound_q;
          end else begin
            half_d = half_q - 1'b1;
          end
        end
      end
      default: begin
        sound_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      dur_q   <= '0;
      half_q  <= '0;
      sound_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      half_q  <= half_d;
      sound_q <= sound_d;
      busy_q  <= busy_d;
    end
  end

  assign sq.sound    = sound_q;
  assign sq.busy     = busy_q;
  assign sq.note_idx = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: timeline model of the melody checked every
// cycle, plus directed literal checks at note and toggle boundaries.
module tb_tone_sequencer;

  localparam int NC = 1000;
  localparam int HS = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  tone_sequencer_if bus ();

  tone_sequencer #(
    .NOTE_CYCLES(NC),
    .HALF_SHIFT (HS),
    .DIV_W      (16)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .sq   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int raw_hp(input int sel, input int n);
    int jump[2];
    int win[8];
    int lose[4];
    jump = '{14205, 11939};
    win  = '{23900, 18968, 15944, 11939, 0, 15944, 11939, 11939};
    lose = '{31888, 37879, 47710, 0};
    case (sel)
      0:       return jump[n];
      1:       return win[n];
      2:       return lose[n];
      default: return 0;
    endcase
  endfunction

  function automatic int mlen(input int sel);
    case (sel)
      0:       return 2;
      1:       return 8;
      2:       return 4;
      default: return 0;
    endcase
  endfunction

  // Model: "active" and edges elapsed since the last start event.
  bit   m_act;
  int   m_t;
  int   m_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_t   <= 0;
      m_sel <= 0;
    end else if (!bus.enable) begin
      m_act <= 1'b0;
    end else if (!m_act || bus.restart) begin
      m_act <= 1'b1;
      m_t   <= 0;
      m_sel <= int'(bus.melody_sel);
    end else if (m_t < 1000000) begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    int n;
    int len;
    int hp;
    int e_s;
    int e_b;
    int e_i;
    if (!rst) begin
      e_s = 0;
      e_b = 0;
      e_i = 0;
      if (m_act) begin
        len = mlen(m_sel);
        n   = m_t / NC;
        if (n >= len) begin
          e_i = (len == 0) ? 0 : len - 1;
        end else begin
          hp  = raw_hp(m_sel, n) >> HS;
          e_b = 1;
          e_i = n;
          e_s = (hp == 0) ? 0 : ((m_t % NC) / hp) % 2;
        end
      end
      chk("model_sound", 32'(bus.sound), 32'(e_s));
      chk("model_busy", 32'(bus.busy), 32'(e_b));
      chk("model_idx", 32'(bus.note_idx), 32'(e_i));
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.restart = 1'b0;
    bus.melody_sel = 2'd0;
    step(3);
    chk("rst_sound", 32'(bus.sound), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_idx", 32'(bus.note_idx), 0);
    rst = 1'b0;
    step(2);

    // win
    bus.melody_sel = 2'd1;
    bus.enable = 1'b1;
    step(1);
    chk("win_busy0", 32'(bus.busy), 1);
    chk("win_idx0", 32'(bus.note_idx), 0);
    step(92);
    chk("win_t92", 32'(bus.sound), 0);
    step(1);
    chk("win_t93", 32'(bus.sound), 1);
    step(93);
    chk("win_t186", 32'(bus.sound), 0);
    step(814);
    chk("win_idx1", 32'(bus.note_idx), 1);
    step(3500);
    chk("win_idx4", 32'(bus.note_idx), 4);
    chk("win_rest", 32'(bus.sound), 0);
    step(3499);
    chk("win_idx7", 32'(bus.note_idx), 7);
    chk("win_busy7", 32'(bus.busy), 1);
    step(1);
    chk("win_done_busy", 32'(bus.busy), 0);
    chk("win_done_idx", 32'(bus.note_idx), 7);
    chk("win_done_snd", 32'(bus.sound), 0);
    step(5);
    chk("win_hold_idx", 32'(bus.note_idx), 7);
    bus.enable = 1'b0;
    step(1);
    chk("win_off_idx", 32'(bus.note_idx), 0);

    // lose
    bus.melody_sel = 2'd2;
    bus.enable = 1'b1;
    step(124);
    chk("lose_t123", 32'(bus.sound), 0);
    step(1);
    chk("lose_t124", 32'(bus.sound), 1);
    step(2061);
    chk("lose_idx2", 32'(bus.note_idx), 2);
    chk("lose_t2185", 32'(bus.sound), 0);
    step(1);
    chk("lose_t2186", 32'(bus.sound), 1);
    step(1814);
    chk("lose_done_busy", 32'(bus.busy), 0);
    chk("lose_done_idx", 32'(bus.note_idx), 3);
    bus.enable = 1'b0;
    step(1);

    // jump with enable drop
    bus.melody_sel = 2'd0;
    bus.enable = 1'b1;
    step(1501);
    chk("jump_idx1", 32'(bus.note_idx), 1);
    bus.enable = 1'b0;
    step(1);
    chk("drop_busy", 32'(bus.busy), 0);
    chk("drop_idx", 32'(bus.note_idx), 0);
    chk("drop_snd", 32'(bus.sound), 0);
    bus.enable = 1'b1;
    step(55);
    chk("jump_t54", 32'(bus.sound), 0);
    step(1);
    chk("jump_t55", 32'(bus.sound), 1);

    // restart on the final edge of note 1
    step(1944);
    chk("rs_pre_idx", 32'(bus.note_idx), 1);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("rs_busy", 32'(bus.busy), 1);
    chk("rs_idx", 32'(bus.note_idx), 0);
    step(2000);
    chk("rs_done_busy", 32'(bus.busy), 0);
    chk("rs_done_idx", 32'(bus.note_idx), 1);
    bus.enable = 1'b0;
    step(2);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("rs_off_busy", 32'(bus.busy), 0);
    step(3);
    chk("rs_off_idx", 32'(bus.note_idx), 0);

    // reserved selection
    bus.melody_sel = 2'd3;
    bus.enable = 1'b1;
    step(1);
    chk("sel3_busy", 32'(bus.busy), 0);
    step(20);
    chk("sel3_snd", 32'(bus.sound), 0);
    bus.enable = 1'b0;
    step(1);

    // selection change mid-melody
    bus.melody_sel = 2'd1;
    bus.enable = 1'b1;
    step(101);
    bus.melody_sel = 2'd2;
    step(900);
    chk("chg_idx1", 32'(bus.note_idx), 1);
    step(3500);
    chk("chg_idx4", 32'(bus.note_idx), 4);
    chk("chg_busy", 32'(bus.busy), 1);
    step(570);
    chk("chg_t5070", 32'(bus.sound), 1);

    // asynchronous reset mid-note
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.enable = 1'b0;
    #1;
    chk("arst_sound", 32'(bus.sound), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_idx", 32'(bus.note_idx), 0);
    step(2);
    rst = 1'b0;
    step(50);
    chk("post_busy", 32'(bus.busy), 0);
    chk("post_idx", 32'(bus.note_idx), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Multi-note square-wave melody generator for the game audio path.
- Sits directly upstream of the audio arbiter: one instance per sound (jump / win / lose), selected by `melody_sel`.
- Gated by the arbiter's per-sound enable; its `sound` output feeds the arbiter's sound-routing mux.
- Steps through a fixed note table:
  - each note is held for `NOTE_CYCLES` clocks;
  - each note is a 50% square wave of the tabulated half-period.

Parameters:
- NOTE_CYCLES, 1562500, clocks per note (8 notes = 12,500,000 = win/lose window).
- HALF_SHIFT, 0, right-shift applied to every table half-period (bench speed-up; 0 in product).
- DIV_W, 16, half-period counter width.

Ports:
- clk  in  1  system clock (25 MHz in product).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; high = play, low = silence and return to IDLE.
- restart  in  1  single-cycle pulse; restarts the melody from note 0 while enabled.
- melody_sel  in  2  0=jump, 1=win, 2=lose, 3=reserved; latched at start.
- sound  out  1  square-wave output.
- busy  out  1  high while in PLAY.
- note_idx  out  3  index of the current note.

Behaviour:
- Reset: all outputs and state cleared asynchronously.
  - State = IDLE; `sound`, `busy`, `note_idx` = 0.
  - Counters = 0; latched selection = 0.
- Note tables (half-period in clocks, 0 = rest):
  - jump (length 2): 14205, 11939.
  - win (length 8): 23900, 18968, 15944, 11939, 0, 15944, 11939, 11939.
  - lose (length 4): 31888, 37879, 47710, 0.
  - sel 3: length 0.
  - Effective half-period `hp = table >> HALF_SHIFT`. An `hp` of 0 is treated as a rest.
- States: IDLE, PLAY, DONE.
- IDLE → PLAY: on the first clock edge with `enable=1` (start event).
  - Latch `melody_sel`; `note_idx=0`.
  - Duration counter = NOTE_CYCLES-1; half counter = hp(0)-1; `sound=0`.
  - `busy` rises on that same edge.
  - If the latched length is 0, go to DONE instead.
- PLAY, each cycle:
  - Duration counter decrements.
  - Tone generation:
    - If the note is not a rest: half counter decrements; at 0 it reloads to hp-1 and `sound` toggles.
    - First toggle occurs hp clocks after note start.
    - If the note is a rest: `sound` is held at 0.
  - When the duration counter reaches 0 (the NOTE_CYCLES-th cycle of the note):
    - If `note_idx` = length-1: go to DONE.
    - Otherwise: increment `note_idx`, reload the duration counter, set half counter = hp(next)-1, force `sound=0`.
- DONE: `sound=0`, `busy=0`, `note_idx` held at the last note. Stays in DONE until `enable` goes low.
- `enable` low in any state: next edge → IDLE with `sound=0`, `busy=0`, `note_idx=0`. This has priority over everything except reset.
- `restart=1` with `enable=1` in PLAY or DONE:
  - Same actions as a start event: re-latch `melody_sel`, go to PLAY.
  - Restart wins over a coincident note advance or DONE transition.
- `restart` with `enable=0`: ignored.
- `melody_sel` changes mid-melody: no effect until the next start or restart.
- Reset asserted mid-note: immediate silence; after deassert, the block waits in IDLE for an `enable` edge (level-high `enable` re-starts on the first clock).
- Counter widths:
  - Duration counter ≥ clog2(NOTE_CYCLES).
  - Half counter is DIV_W; 47710 fits in 16 bits.
  - No wrap-around; reload occurs strictly at 0.

Test Plan:
- Reset/idle: assert reset mid-PLAY → `sound`, `busy`, `note_idx` = 0 immediately (asynchronous); after release with `enable=0` for 50 clocks, outputs stay 0.
- Win melody, bench params NOTE_CYCLES=1000, HALF_SHIFT=8:
  - Raise `enable` with sel=1; `busy=1` next edge.
  - Note 0: `sound` toggles every 93 clocks (23900>>8).
  - `note_idx` steps 0..7 every 1000 clocks.
  - Note 4 is silent.
  - After 8000 clocks: DONE, `busy=0`, `sound=0`, `note_idx=7`.
- Lose melody, same params, sel=2:
  - Note 0 toggles every 124 clocks; note 2 every 186 clocks (47710>>8).
  - Note 3 silent; DONE at 4000 clocks, `note_idx=3`.
- Enable drop: sel=0, drop `enable` at clock 1500 → next edge IDLE, `sound=0`, `note_idx=0`. Re-raise → restarts at note 0 with the 55-clock half-period.
- Restart priority:
  - Pulse `restart` on the exact cycle note 1 of jump would end → PLAY at note 0, `busy` remains 1.
  - Pulse `restart` with `enable=0` → no change.
- Reserved sel=3 and mid-melody sel change:
  - sel=3 start → DONE on first edge, `busy` never 1, `sound` stays 0.
  - Changing sel during win playback leaves the win sequence unaffected.
